// File: rtl/fetch_pkg.sv
// Shared fetch definitions: widths, HALT opcode, fetch FSM state encoding and
// the opcode-field helper. Also imported by the decoder.
package fetch_pkg;

    localparam int unsigned PC_W    = 8;   // program counter / imem address width
    localparam int unsigned INSTR_W = 16;  // instruction width
    localparam int unsigned OPC_W   = 4;   // opcode field width (top bits of instr)
    localparam int unsigned CNT_W   = 16;  // issued-instruction counter width

    localparam logic [OPC_W-1:0] HALT_OPC = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

    // Opcode lives in the most significant OPC_W bits of an instruction.
    function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for the better_processor core.
// Owns the PC, reads a synchronous (1-cycle latency) instruction memory and
// offers each fetched instruction to decode over a valid/ready handshake.
// Branch redirects from execute squash the in-flight fetch; a HALT opcode
// stops fetch until the next start pulse.
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   start          1-cycle pulse, begin fetch at PC 0 (IDLE/HALTED only)
//   imem_en        memory read enable (REQ state)
//   imem_addr      memory read address (PC in REQ, else 0)
//   imem_rdata     memory read data, valid the cycle after imem_en
//   instr_out      instruction offered to decode
//   instr_pc       address of instr_out
//   instr_valid    instr_out valid (suppressed in a branch cycle)
//   instr_ready    decode accepts instr_out
//   branch_taken   redirect request from execute
//   branch_target  redirect address
//   busy           high in REQ, WAIT or ISSUE
//   halted         high in HALTED
//   issue_count    saturating count of handshakes since start/reset
module fetch_sequencer
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               busy,
    output logic               halted,
    output logic [CNT_W-1:0]   issue_count
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [PC_W-1:0] pc;

    logic restart_c;   // start accepted this cycle
    logic redirect_c;  // branch accepted this cycle
    logic transfer_c;  // handshake completes this cycle
    logic is_halt_c;   // offered instruction is HALT

    // Status decodes of the state register.
    assign busy        = (state == REQ) || (state == WAIT) || (state == ISSUE);
    assign halted      = (state == HALTED);
    assign restart_c   = start && ((state == IDLE) || (state == HALTED));
    assign redirect_c  = branch_taken && busy;

    // Memory request; address forced to 0 outside REQ so idle outputs are quiet.
    assign imem_en     = (state == REQ);
    assign imem_addr   = imem_en ? pc : '0;

    // A branch in ISSUE withdraws the offer so no transfer can slip through.
    assign instr_valid = (state == ISSUE) && !branch_taken;
    assign transfer_c  = instr_valid && instr_ready;
    assign is_halt_c   = (get_opcode(instr_out) == HALT_OPC);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a redirect overrides every busy-state transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (restart_c) state_nxt = REQ;
            REQ:     state_nxt = WAIT;
            WAIT:    state_nxt = ISSUE;
            ISSUE:   if (transfer_c) state_nxt = is_halt_c ? HALTED : REQ;
            HALTED:  if (restart_c) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
        if (redirect_c) begin
            state_nxt = REQ;
        end
    end

    // PC, captured instruction and issue counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_pc    <= '0;
            issue_count <= '0;
        end else begin
            if (restart_c) begin
                pc          <= '0;
                issue_count <= '0;
            end else if (redirect_c) begin
                // Squash: WAIT data is dropped and pc is not advanced.
                pc <= branch_target;
            end else if (state == WAIT) begin
                instr_out <= imem_rdata;
                instr_pc  <= pc;
                pc        <= pc + PC_W'(1);
            end

            if (transfer_c && (issue_count != {CNT_W{1'b1}})) begin
                issue_count <= issue_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Sequences instruction fetch for the better_processor core. It owns the 8-bit program counter and drives a synchronous 256x16 instruction memory with 1-cycle read latency. It hands each fetched instruction to decode through a valid/ready handshake. It also handles branch redirects from execute, halts on a HALT opcode, and restarts on `start`.

Parameters:
- PC_W, 8, program counter / instruction memory address width
- INSTR_W, 16, instruction width
- OPC_W, 4, opcode field width (instruction bits [INSTR_W-1 -: OPC_W])
- HALT_OPC, 4'hF, opcode value that halts fetch
- CNT_W, 16, width of the issued-instruction counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  1-cycle pulse; begins fetch from PC 0 (accepted in IDLE or HALTED only)
- imem_en  output  1  memory read enable
- imem_addr  output  PC_W  memory read address
- imem_rdata  input  INSTR_W  memory read data, valid the cycle after imem_en
- instr_out  output  INSTR_W  instruction offered to decode
- instr_pc  output  PC_W  address of instr_out
- instr_valid  output  1  instr_out is valid
- instr_ready  input  1  decode accepts instr_out
- branch_taken  input  1  redirect request from execute
- branch_target  input  PC_W  redirect address
- busy  output  1  high in REQ, WAIT or ISSUE
- halted  output  1  high in HALTED
- issue_count  output  CNT_W  number of completed handshakes since last start/reset

Behaviour:
Reset (synchronous, active-high):
- state=IDLE; pc=0.
- All outputs 0: imem_en, imem_addr, instr_out, instr_pc, instr_valid, busy, halted, issue_count.
- Reset overrides every other input in the same cycle, including mid-fetch and mid-handshake.

FSM states: IDLE, REQ, WAIT, ISSUE, HALTED.
- IDLE: start -> pc=0, issue_count=0, go REQ. All other inputs are ignored.
- REQ: imem_en=1, imem_addr=pc (combinational from state/pc). Go WAIT.
- WAIT: capture imem_rdata into instr_out and pc into instr_pc; pc=pc+1 modulo 2^PC_W; go ISSUE.
- ISSUE: instr_valid=1. A transfer occurs when instr_valid & instr_ready in the same cycle.
  - On transfer, issue_count increments (saturates at all-ones).
  - On transfer with opcode==HALT_OPC -> HALTED.
  - On transfer with any other opcode -> REQ.
  - Without instr_ready, hold instr_out/instr_pc stable and stay in ISSUE.
- HALTED: halted=1. start -> same action as from IDLE. branch_taken is ignored.

Latency and throughput:
- start to first instr_valid: 3 cycles (REQ, WAIT, then ISSUE).
- Steady state with instr_ready tied high: one instruction per 3 cycles.

Branch redirect (REQ, WAIT or ISSUE):
- branch_taken has priority over all other transitions: pc=branch_target, go REQ.
- The in-flight fetch is squashed: WAIT data is discarded and pc is not incremented.
- In ISSUE, instr_valid = (state==ISSUE) & ~branch_taken. No transfer can occur in the branch cycle, and issue_count does not increment.
- branch_taken in IDLE or HALTED has no effect.

Boundary conditions:
- PC wraps: 0xFF increments to 0x00 with no flag.
- start while busy is ignored.
- start and branch_taken together in HALTED: start wins.
- A HALT instruction squashed by a branch does not halt.

Arithmetic: pc and the counter are unsigned; all additions are truncated to the declared width, except issue_count, which saturates.

Decomposition:
- Shared package fetch_pkg holds:
  - state enum fetch_state_t {IDLE, REQ, WAIT, ISSUE, HALTED}
  - PC_W and INSTR_W constants
  - HALT_OPC constant
  - function get_opcode(instr)
- The package is shared with the decoder.
- No sub-module; it is a single FSM plus datapath registers. Integration testing pairs it with the existing instruction memory model.

Test Plan:
- Memory = {0x1000, 0x2001, 0xF000}; reset, start pulse, instr_ready=1 -> instr_valid first at cycle 3 after start. Issued (pc, instr) = (0,0x1000), (1,0x2001), (2,0xF000); then halted=1, busy=0, issue_count=3.
- Same program with instr_ready low for 5 cycles on the first issue -> instr_out holds 0x1000, instr_pc holds 0, no memory read issued, count unchanged until ready rises.
- branch_taken=1, target=0x40, asserted in ISSUE for pc 1 -> instr_valid=0 that cycle, count not incremented. Next imem_addr=0x40, and the next issued instr_pc=0x40.
- branch_taken asserted in WAIT -> captured data discarded, next REQ address = target, pc not incremented.
- Memory all 0x1111, run to pc 0xFF -> next fetch address 0x00, fetch continues.
- reset asserted in WAIT -> next cycle state IDLE, all outputs 0. start then restarts at pc 0. start pulse while busy is ignored.
